// File: rtl/snake_body_engine_if.sv
// Snake engine bus: controls, apple and query inputs toward the core, state and query results back.
// Pure wiring, no latency of its own.
// No backpressure: every signal is a level or a single-cycle strobe.
interface snake_body_engine_if #(
  parameter int GRID_W  = 64,
  parameter int GRID_H  = 48,
  parameter int MAX_LEN = 128
);
  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);
  localparam int L_W = $clog2(MAX_LEN + 1);

  logic           start;
  logic           tick;
  logic           BTNU;
  logic           BTND;
  logic           BTNL;
  logic           BTNR;
  logic [X_W-1:0] apple_x;
  logic [Y_W-1:0] apple_y;
  logic [X_W-1:0] qry_x;
  logic [Y_W-1:0] qry_y;
  logic           hit_head;
  logic           hit_body;
  logic [X_W-1:0] head_x;
  logic [Y_W-1:0] head_y;
  logic [L_W-1:0] length;
  logic           ate;
  logic           game_over;
  logic           busy;

  // master: game control / renderer side
  modport master (
    output start, tick, BTNU, BTND, BTNL, BTNR, apple_x, apple_y, qry_x, qry_y,
    input  hit_head, hit_body, head_x, head_y, length, ate, game_over, busy
  );

  // slave: the snake core
  modport slave (
    input  start, tick, BTNU, BTND, BTNL, BTNR, apple_x, apple_y, qry_x, qry_y,
    output hit_head, hit_body, head_x, head_y, length, ate, game_over, busy
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake game core: segment store, steering, growth, border/self collision, cell query port.
// Latency: one MOVE cycle per tick (head/length/ate visible the cycle after MOVE); query 1 cycle.
// No backpressure: ticks arriving outside RUN are dropped; start low aborts to IDLE.
// Ports: CLK, RST_N (async active-low); bus (slave modport) carries start/tick/buttons,
// apple and query coordinates in, and head/length/ate/game_over/busy/hit flags out.
module snake_body_engine #(
  parameter int GRID_W    = 64,
  parameter int GRID_H    = 48,
  parameter int MAX_LEN   = 128,
  parameter int START_LEN = 3,
  parameter int WRAP      = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  snake_body_engine_if.slave  bus
);
  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);
  localparam int L_W = $clog2(MAX_LEN + 1);

  localparam logic [X_W-1:0] X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [L_W-1:0] LEN_MAX   = L_W'(MAX_LEN);
  localparam logic [L_W-1:0] LEN_START = L_W'(START_LEN);
  localparam logic [L_W-1:0] LEN_ONE   = L_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_MOVE, S_DEAD} state_t;
  // Encoding chosen so the opposite direction is dir ^ 2'b10.
  typedef enum logic [1:0] {DIR_R, DIR_U, DIR_L, DIR_D} dir_t;

  state_t         state_q, state_d;
  dir_t           dir_q, dir_d;
  logic [L_W-1:0] len_q, len_d;
  logic           ate_q, ate_d;
  logic           hit_head_q, hit_head_d;
  logic           hit_body_q, hit_body_d;
  logic [X_W-1:0] seg_x_q [MAX_LEN];
  logic [X_W-1:0] seg_x_d [MAX_LEN];
  logic [Y_W-1:0] seg_y_q [MAX_LEN];
  logic [Y_W-1:0] seg_y_d [MAX_LEN];

  logic [X_W-1:0] nh_x;
  logic [Y_W-1:0] nh_y;
  logic           off_grid;
  logic           eat;
  logic           self_hit;
  logic           lethal;
  dir_t           dir_req;
  logic           reverse;

  // Next head position; off_grid flags a step across an edge, nh already holds the wrapped cell.
  always_comb begin
    nh_x     = seg_x_q[0];
    nh_y     = seg_y_q[0];
    off_grid = 1'b0;
    case (dir_q)
      DIR_R: begin
        if (seg_x_q[0] == X_MAX) begin
          off_grid = 1'b1;
          nh_x     = '0;
        end else begin
          nh_x = seg_x_q[0] + X_W'(1);
        end
      end
      DIR_L: begin
        if (seg_x_q[0] == '0) begin
          off_grid = 1'b1;
          nh_x     = X_MAX;
        end else begin
          nh_x = seg_x_q[0] - X_W'(1);
        end
      end
      DIR_U: begin
        if (seg_y_q[0] == '0) begin
          off_grid = 1'b1;
          nh_y     = Y_MAX;
        end else begin
          nh_y = seg_y_q[0] - Y_W'(1);
        end
      end
      default: begin
        if (seg_y_q[0] == Y_MAX) begin
          off_grid = 1'b1;
          nh_y     = '0;
        end else begin
          nh_y = seg_y_q[0] + Y_W'(1);
        end
      end
    endcase
  end

  assign eat = (nh_x == bus.apple_x) && (nh_y == bus.apple_y);

  // Self collision against the body; the tail cell is free unless the snake grows this move.
  always_comb begin
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((L_W'(i) < len_q) && (eat || (L_W'(i) != len_q - LEN_ONE)) &&
          (seg_x_q[i] == nh_x) && (seg_y_q[i] == nh_y)) begin
        self_hit = 1'b1;
      end
    end
  end

  assign lethal = (off_grid && (WRAP == 0)) || self_hit;

  // Button priority D > L > U > R; a request pointing straight back is ignored.
  always_comb begin
    dir_req = dir_q;
    if (bus.BTND)      dir_req = DIR_D;
    else if (bus.BTNL) dir_req = DIR_L;
    else if (bus.BTNU) dir_req = DIR_U;
    else if (bus.BTNR) dir_req = DIR_R;
  end

  assign reverse = (dir_req == dir_t'(dir_q ^ 2'b10));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    len_d   = len_q;
    ate_d   = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_x_d[i] = seg_x_q[i];
      seg_y_d[i] = seg_y_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_INIT;
      end
      S_INIT: begin
        for (int i = 0; i < START_LEN; i++) begin
          seg_x_d[i] = X_W'(GRID_W / 2 - i);
          seg_y_d[i] = Y_W'(GRID_H / 2);
        end
        len_d   = LEN_START;
        dir_d   = DIR_R;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!reverse) dir_d = dir_req;
        if (bus.tick) state_d = S_MOVE;
      end
      S_MOVE: begin
        if (lethal) begin
          state_d = S_DEAD;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = nh_x;
          seg_y_d[0] = nh_y;
          if (eat && (len_q < LEN_MAX)) len_d = len_q + LEN_ONE;
          ate_d   = eat;
          state_d = S_RUN;
        end
      end
      S_DEAD: begin
        // Frozen until start drops.
      end
      default: state_d = S_IDLE;
    endcase

    if (!bus.start) begin
      state_d = S_IDLE;
      len_d   = '0;
      ate_d   = 1'b0;
    end
  end

  // Query port: segments beyond len_q are stale and masked out.
  always_comb begin
    hit_head_d = (len_q != '0) && (seg_x_q[0] == bus.qry_x) && (seg_y_q[0] == bus.qry_y);
    hit_body_d = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((L_W'(i) < len_q) && (seg_x_q[i] == bus.qry_x) && (seg_y_q[i] == bus.qry_y)) begin
        hit_body_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      dir_q      <= DIR_R;
      len_q      <= '0;
      ate_q      <= 1'b0;
      hit_head_q <= 1'b0;
      hit_body_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      len_q      <= len_d;
      ate_q      <= ate_d;
      hit_head_q <= hit_head_d;
      hit_body_q <= hit_body_d;
    end
  end

  // Segment store has no reset: contents are meaningless while len_q is 0.
  always_ff @(posedge CLK) begin
    seg_x_q <= seg_x_d;
    seg_y_q <= seg_y_d;
  end

  assign bus.head_x    = (len_q != '0) ? seg_x_q[0] : '0;
  assign bus.head_y    = (len_q != '0) ? seg_y_q[0] : '0;
  assign bus.length    = len_q;
  assign bus.ate       = ate_q;
  assign bus.game_over = (state_q == S_DEAD);
  assign bus.busy      = (state_q == S_MOVE);
  assign bus.hit_head  = hit_head_q;
  assign bus.hit_body  = hit_body_q;
endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: two instances (border-lethal and wrapping) share one stimulus.
// Latency: expected state pushed when a tick/query is driven, popped once the DUT has produced it.
// No backpressure in the DUT; all waits are fixed cycle counts.
module tb_snake_body_engine;
  localparam int GW = 64;
  localparam int GH = 48;
  localparam int ML = 8;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic       start = 1'b0, tick = 1'b0;
  logic       btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
  logic [5:0] apple_x = 6'd5, apple_y = 6'd40, qry_x = 6'd0, qry_y = 6'd0;

  snake_body_engine_if #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML)) bi0 ();
  snake_body_engine_if #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML)) bi1 ();

  assign bi0.start = start;   assign bi1.start = start;
  assign bi0.tick = tick;     assign bi1.tick = tick;
  assign bi0.BTNU = btnu;     assign bi1.BTNU = btnu;
  assign bi0.BTND = btnd;     assign bi1.BTND = btnd;
  assign bi0.BTNL = btnl;     assign bi1.BTNL = btnl;
  assign bi0.BTNR = btnr;     assign bi1.BTNR = btnr;
  assign bi0.apple_x = apple_x; assign bi1.apple_x = apple_x;
  assign bi0.apple_y = apple_y; assign bi1.apple_y = apple_y;
  assign bi0.qry_x = qry_x;   assign bi1.qry_x = qry_x;
  assign bi0.qry_y = qry_y;   assign bi1.qry_y = qry_y;

  snake_body_engine #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .START_LEN(3), .WRAP(0))
    u0 (.CLK(CLK), .RST_N(RST_N), .bus(bi0));
  snake_body_engine #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .START_LEN(3), .WRAP(1))
    u1 (.CLK(CLK), .RST_N(RST_N), .bus(bi1));

  // Reference snake per instance: index 0 = head.
  int mx [2][ML];
  int my [2][ML];
  int mlen [2];
  int mdir [2];  // 0 R, 1 U, 2 L, 3 D
  int mdead [2];

  typedef struct {int inst; int hx; int hy; int len; int ate; int dead;} exp_t;
  typedef struct {int inst; int h; int b;} qexp_t;
  typedef struct {int qx; int qy; int h; int b;} vec_t;
  exp_t  exp_q[$];
  qexp_t qexp_q[$];
  vec_t  vecs[6];

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic get_out(input int k, output int hx, output int hy, output int len,
                         output int ate, output int dead, output int busy,
                         output int hh, output int hb);
    if (k == 0) begin
      hx = int'(bi0.head_x); hy = int'(bi0.head_y); len = int'(bi0.length);
      ate = int'(bi0.ate); dead = int'(bi0.game_over); busy = int'(bi0.busy);
      hh = int'(bi0.hit_head); hb = int'(bi0.hit_body);
    end else begin
      hx = int'(bi1.head_x); hy = int'(bi1.head_y); len = int'(bi1.length);
      ate = int'(bi1.ate); dead = int'(bi1.game_over); busy = int'(bi1.busy);
      hh = int'(bi1.hit_head); hb = int'(bi1.hit_body);
    end
  endtask

  task automatic push_exp(int k, int ate);
    exp_t e;
    e.inst = k;
    e.hx   = (mlen[k] != 0) ? mx[k][0] : 0;
    e.hy   = (mlen[k] != 0) ? my[k][0] : 0;
    e.len  = mlen[k];
    e.ate  = ate;
    e.dead = mdead[k];
    exp_q.push_back(e);
  endtask

  task automatic check_state(string tag);
    exp_t e;
    int hx, hy, len, ate, dead, busy, hh, hb;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_out(e.inst, hx, hy, len, ate, dead, busy, hh, hb);
      chk($sformatf("%s_u%0d_head_x", tag, e.inst), hx, e.hx);
      chk($sformatf("%s_u%0d_head_y", tag, e.inst), hy, e.hy);
      chk($sformatf("%s_u%0d_length", tag, e.inst), len, e.len);
      chk($sformatf("%s_u%0d_ate", tag, e.inst), ate, e.ate);
      chk($sformatf("%s_u%0d_game_over", tag, e.inst), dead, e.dead);
    end
  endtask

  task automatic model_init();
    for (int k = 0; k < 2; k++) begin
      mlen[k] = 3; mdir[k] = 0; mdead[k] = 0;
      for (int i = 0; i < 3; i++) begin
        mx[k][i] = GW / 2 - i;
        my[k][i] = GH / 2;
      end
    end
  endtask

  task automatic model_move(input int k, input int wrap, input int bu, input int bd,
                            input int bl, input int br, output int ate);
    int req, nx, ny, eat, lethal, keep;
    ate = 0;
    if (mdead[k] == 0) begin
      req = mdir[k];
      if (bd != 0)      req = 3;
      else if (bl != 0) req = 2;
      else if (bu != 0) req = 1;
      else if (br != 0) req = 0;
      if (req != (mdir[k] + 2) % 4) mdir[k] = req;
      nx = mx[k][0]; ny = my[k][0];
      case (mdir[k])
        0: nx = nx + 1;
        1: ny = ny - 1;
        2: nx = nx - 1;
        default: ny = ny + 1;
      endcase
      lethal = 0;
      if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
        if (wrap != 0) begin
          nx = (nx + GW) % GW;
          ny = (ny + GH) % GH;
        end else begin
          lethal = 1;
        end
      end
      eat = (nx == int'(apple_x) && ny == int'(apple_y)) ? 1 : 0;
      // cells still occupied after the move: the whole body when growing, else all but the tail
      keep = (eat != 0) ? mlen[k] : mlen[k] - 1;
      for (int i = 1; i < keep; i++)
        if (mx[k][i] == nx && my[k][i] == ny) lethal = 1;
      if (lethal != 0) begin
        mdead[k] = 1;
      end else begin
        for (int i = ML - 1; i > 0; i--) begin
          mx[k][i] = mx[k][i-1];
          my[k][i] = my[k][i-1];
        end
        mx[k][0] = nx; my[k][0] = ny;
        if (eat != 0 && mlen[k] < ML) mlen[k] = mlen[k] + 1;
        ate = eat;
      end
    end
  endtask

  task automatic do_tick(int bu, int bd, int bl, int br, int hold2);
    int a0, a1, d0, d1, hx, hy, len, ate, dead, busy, hh, hb;
    d0 = mdead[0]; d1 = mdead[1];
    btnu = (bu != 0); btnd = (bd != 0); btnl = (bl != 0); btnr = (br != 0);
    tick = 1'b1;
    model_move(0, 0, bu, bd, bl, br, a0);
    model_move(1, 1, bu, bd, bl, br, a1);
    push_exp(0, a0);
    push_exp(1, a1);
    cyc();
    btnu = 1'b0; btnd = 1'b0; btnl = 1'b0; btnr = 1'b0;
    get_out(0, hx, hy, len, ate, dead, busy, hh, hb);
    chk("move_u0_busy", busy, (d0 != 0) ? 0 : 1);
    get_out(1, hx, hy, len, ate, dead, busy, hh, hb);
    chk("move_u1_busy", busy, (d1 != 0) ? 0 : 1);
    tick = (hold2 != 0);
    cyc();
    tick = 1'b0;
    check_state("tick");
    cyc();
    get_out(0, hx, hy, len, ate, dead, busy, hh, hb);
    chk("ate_clear_u0", ate, 0);
    get_out(1, hx, hy, len, ate, dead, busy, hh, hb);
    chk("ate_clear_u1", ate, 0);
  endtask

  task automatic restart();
    start = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++) begin
      mlen[k] = 0; mdead[k] = 0;
      push_exp(k, 0);
    end
    check_state("idle");
    start = 1'b1;
    cyc();
    cyc();
    model_init();
    push_exp(0, 0);
    push_exp(1, 0);
    check_state("init");
  endtask

  task automatic query_exp(int x, int y, int h, int b);
    qexp_t q;
    int hx, hy, len, ate, dead, busy, hh, hb;
    qry_x = 6'(x); qry_y = 6'(y);
    for (int k = 0; k < 2; k++) begin
      q.inst = k; q.h = h; q.b = b;
      qexp_q.push_back(q);
    end
    cyc();
    while (qexp_q.size() > 0) begin
      q = qexp_q.pop_front();
      get_out(q.inst, hx, hy, len, ate, dead, busy, hh, hb);
      chk($sformatf("qry_u%0d_%0d_%0d_hit_head", q.inst, x, y), hh, q.h);
      chk($sformatf("qry_u%0d_%0d_%0d_hit_body", q.inst, x, y), hb, q.b);
    end
  endtask

  // Per-instance model query (instances may differ after the wrap test).
  task automatic query_model(int k, int x, int y);
    int h, b, hx, hy, len, ate, dead, busy, hh, hb;
    h = (mlen[k] != 0 && mx[k][0] == x && my[k][0] == y) ? 1 : 0;
    b = 0;
    for (int i = 1; i < mlen[k]; i++)
      if (mx[k][i] == x && my[k][i] == y) b = 1;
    qry_x = 6'(x); qry_y = 6'(y);
    cyc();
    get_out(k, hx, hy, len, ate, dead, busy, hh, hb);
    chk($sformatf("mqry_u%0d_%0d_%0d_hit_head", k, x, y), hh, h);
    chk($sformatf("mqry_u%0d_%0d_%0d_hit_body", k, x, y), hb, b);
  endtask

  initial begin
    int hx, hy, len, ate, dead, busy, hh, hb;
    vecs[0] = '{32, 24, 1, 0};
    vecs[1] = '{31, 24, 0, 1};
    vecs[2] = '{30, 24, 0, 1};
    vecs[3] = '{29, 24, 0, 0};
    vecs[4] = '{33, 24, 0, 0};
    vecs[5] = '{32, 23, 0, 0};

    // Reset state
    cyc();
    cyc();
    for (int k = 0; k < 2; k++) begin
      get_out(k, hx, hy, len, ate, dead, busy, hh, hb);
      chk($sformatf("rst_u%0d_head_x", k), hx, 0);
      chk($sformatf("rst_u%0d_head_y", k), hy, 0);
      chk($sformatf("rst_u%0d_length", k), len, 0);
      chk($sformatf("rst_u%0d_ate", k), ate, 0);
      chk($sformatf("rst_u%0d_game_over", k), dead, 0);
      chk($sformatf("rst_u%0d_busy", k), busy, 0);
      chk($sformatf("rst_u%0d_hits", k), hh + hb, 0);
    end
    RST_N = 1'b1;
    cyc();

    // Start: 2 cycles to a 3-segment snake at the centre
    start = 1'b1;
    cyc();
    cyc();
    model_init();
    push_exp(0, 0);
    push_exp(1, 0);
    check_state("start");
    for (int i = 0; i < 6; i++) query_exp(vecs[i].qx, vecs[i].qy, vecs[i].h, vecs[i].b);

    // Five plain ticks
    for (int i = 0; i < 5; i++) do_tick(0, 0, 0, 0, 0);
    chk("five_ticks_head_x", int'(bi0.head_x), 37);
    chk("five_ticks_length", int'(bi0.length), 3);

    // Eat one apple
    restart();
    apple_x = 6'd33; apple_y = 6'd24;
    do_tick(0, 0, 0, 0, 0);
    chk("eat_length", int'(bi0.length), 4);
    apple_x = 6'd5; apple_y = 6'd40;
    query_model(0, 30, 24);
    query_model(0, 29, 24);
    query_model(0, 33, 24);

    // Hold up: border death vs. wrap
    restart();
    for (int i = 0; i < 25; i++) do_tick(1, 0, 0, 0, 0);
    chk("border_u0_game_over", int'(bi0.game_over), 1);
    chk("border_u0_head_y", int'(bi0.head_y), 0);
    chk("wrap_u1_game_over", int'(bi1.game_over), 0);
    chk("wrap_u1_head_y", int'(bi1.head_y), 47);
    do_tick(0, 0, 0, 0, 0);  // ignored by the dead instance
    query_model(0, 32, 0);
    query_model(0, 32, 1);

    // Reversal ignored, tick held through MOVE dropped, tick+turn together
    restart();
    do_tick(0, 0, 1, 0, 0);
    chk("reverse_head_x", int'(bi0.head_x), 33);
    do_tick(0, 0, 0, 0, 1);
    chk("tick_in_move_head_x", int'(bi0.head_x), 34);
    do_tick(0, 1, 1, 1, 0);
    chk("turn_with_tick_head_y", int'(bi0.head_y), 25);

    // Length-4 loop re-enters the vacated tail cell
    restart();
    apple_x = 6'd33; apple_y = 6'd24;
    do_tick(0, 0, 0, 0, 0);
    apple_x = 6'd5; apple_y = 6'd40;
    do_tick(1, 0, 0, 0, 0);
    do_tick(0, 0, 1, 0, 0);
    do_tick(0, 1, 0, 0, 0);
    do_tick(0, 0, 0, 1, 0);
    chk("loop4_game_over", int'(bi0.game_over), 0);

    // Length-5 loop bites the body
    restart();
    apple_x = 6'd33; apple_y = 6'd24;
    do_tick(0, 0, 0, 0, 0);
    apple_x = 6'd34;
    do_tick(0, 0, 0, 0, 0);
    apple_x = 6'd5; apple_y = 6'd40;
    do_tick(1, 0, 0, 0, 0);
    do_tick(0, 0, 1, 0, 0);
    do_tick(0, 1, 0, 0, 0);
    chk("loop5_game_over", int'(bi0.game_over), 1);
    query_model(0, 33, 23);

    // Fill to MAX_LEN and saturate
    restart();
    apple_y = 6'd24;
    for (int i = 0; i < 7; i++) begin
      apple_x = 6'(33 + i);
      do_tick(0, 0, 0, 0, 0);
    end
    chk("saturate_length", int'(bi0.length), ML);
    query_model(0, 32, 24);
    query_model(0, 31, 24);

    start = 1'b0;
    cyc();
    chk("abort_length", int'(bi0.length), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
